sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port (towards the bus bridge) between the CPU's instruction-fetch master and data (load/store) master.
- Grants one address phase per cycle and tracks outstanding transactions in an in-order ID FIFO. Routes each slave data_ok/rdata back to the master that issued the request.
- Sits between the IF/MEM stages and the sram-like-to-AXI bridge in mycpu_top.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unreturned transactions (power of 2, >=2).
- DATA_PRIO, 1, 1 = data master wins simultaneous requests; 0 = round-robin.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction master request
- inst_wr  in  1  write flag
- inst_size  in  2  0/1/2 = 1/2/4 bytes
- inst_addr  in  32  address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addrok  out  1  address accepted
- inst_dataok  out  1  data returned
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data master, same meaning as the inst_* inputs
- data_addrok, data_dataok, data_rdata  out  1/1/32  data master, same meaning as the inst_* outputs
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  1/1/2/32/4/32  to slave
- m_addrok, m_dataok  in  1  slave handshakes
- m_rdata  in  32  slave read data

Behaviour:
- Registers: lock_valid, lock_id, FIFO (OUTSTANDING x 1-bit id, 0 = inst, 1 = data), wr_ptr, rd_ptr, count (clog2(OUTSTANDING)+1 bits), rr_last (round-robin only).
- Async reset (resetn=0) clears all registers. With no requests, every output strobe is 0; rdata outputs mirror m_rdata.
- full = (count == OUTSTANDING). When full, m_req=0 and neither addrok is asserted. Masters simply hold req.
- Grant is combinational:
  - If lock_valid, grant = lock_id.
  - Else, if only one master requests, it wins.
  - Else, if both request: DATA_PRIO=1 gives data; DATA_PRIO=0 gives the master other than rr_last.
- m_req = granted master's req && !full. m_wr, m_size, m_addr, m_wstrb and m_wdata are muxed from the granted master.
- Lock: if m_req && !m_addrok, set lock_valid=1 and lock_id=grant. Clear the lock on the cycle m_req && m_addrok. A master's request, once presented to the slave, is never switched away before acceptance.
- Accept (m_req && m_addrok):
  - Pulse <granted>_addrok in the same cycle (zero latency).
  - Push the grant id at wr_ptr; wr_ptr wraps modulo OUTSTANDING.
  - Update rr_last = grant.
- Return (m_dataok && count != 0):
  - Head id = FIFO[rd_ptr].
  - Assert inst_dataok or data_dataok for that id in the same cycle; rdata is forwarded combinationally.
  - Pop; rd_ptr wraps.
- m_dataok while count == 0 is ignored: no dataok to either master, no pointer change.
- Simultaneous push and pop: count unchanged, both pointers advance. Full blocks push even if a pop occurs in the same cycle.
- Responses are strictly in acceptance order; the slave must return in order.
- Writes also consume a FIFO slot and receive a dataok (write response).
- resetn asserted mid-transaction: FIFO and lock are discarded; late m_dataok is ignored per the empty rule.

Decomposition:
- Shared package/header (mycpu.h): SRAM-like size encodings (SZ_BYTE/HALF/WORD), and ID_INST = 1'b0, ID_DATA = 1'b1.
- One natural sub-module: id_fifo (parameterised depth, 1-bit width, push/pop/full/empty/head, async active-low reset).

Test Plan:
- Single inst read: inst_req=1, addr=0xbfc00000, slave addrok same cycle, dataok 2 cycles later with rdata=0x3c080001 -> inst_addrok pulse in cycle 0, inst_dataok=1 with inst_rdata=0x3c080001 in cycle 2, data_dataok stays 0.
- Conflict, DATA_PRIO=1: both req in the same cycle (inst 0xbfc00004, data 0x80001000) -> m_addr=0x80001000 first, inst granted next cycle; two returns routed data then inst in order.
- Lock: inst presented, m_addrok held 0 for 3 cycles while data_req rises in cycle 1 -> m_addr stays inst's address until accept; data is granted the cycle after.
- Full: OUTSTANDING=4, four accepts with no dataok -> 5th request sees m_req=0; one m_dataok pop in cycle N -> m_req re-asserts in cycle N+1.
- Spurious return: m_dataok=1 with count=0 -> no master dataok, count stays 0. Then a normal read completes correctly.
- Reset mid-flight: two outstanding, resetn pulsed low -> count=0, lock cleared, subsequent m_dataok ignored.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter slice.
//   sram_size_e : SRAM-like transfer size encodings (1/2/4 bytes).
//   master_id_e : transaction owner tag stored in the in-order ID FIFO.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sram_size_e;

  typedef enum logic [0:0] {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } master_id_e;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order 1-bit ID FIFO recording which master owns each outstanding
// transaction.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   push, push_id    : enqueue push_id (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   full, empty      : occupancy flags
//   head             : id at the read pointer
module sram_like_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the instruction-fetch and data
// masters. One address phase is granted per cycle; an in-order ID FIFO
// routes each slave data_ok/rdata back to the issuing master.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   inst_* / data_*    : sram-like master ports (req/wr/size/addr/wstrb/wdata
//                        in, addrok/dataok/rdata out)
//   m_*                : sram-like slave port towards the bridge
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned DATA_PRIO   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addrok,
  output logic        inst_dataok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addrok,
  output logic        data_dataok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addrok,
  input  logic        m_dataok,
  input  logic [31:0] m_rdata
);

  logic       lock_valid_q, lock_valid_d;
  master_id_e lock_id_q, lock_id_d;
  master_id_e rr_last_q, rr_last_d;
  master_id_e grant;
  logic       full, empty, head;
  logic       accept, ret;

  always_comb begin
    grant = ID_INST;
    if (lock_valid_q) begin
      grant = lock_id_q;
    end else if (data_req && !inst_req) begin
      grant = ID_DATA;
    end else if (data_req && inst_req) begin
      grant = (DATA_PRIO != 0) ? ID_DATA : master_id_e'(~rr_last_q);
    end
  end

  always_comb begin
    if (grant == ID_DATA) begin
      m_req   = data_req && !full;
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wstrb = data_wstrb;
      m_wdata = data_wdata;
    end else begin
      m_req   = inst_req && !full;
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wstrb = inst_wstrb;
      m_wdata = inst_wdata;
    end
  end

  assign accept      = m_req && m_addrok;
  assign ret         = m_dataok && !empty;
  assign inst_addrok = accept && (grant == ID_INST);
  assign data_addrok = accept && (grant == ID_DATA);
  assign inst_dataok = ret && (head == ID_INST);
  assign data_dataok = ret && (head == ID_DATA);
  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;

  // A presented-but-unaccepted request pins the grant so the slave never
  // sees the address phase switch masters mid-handshake.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    rr_last_d    = rr_last_q;
    if (accept) begin
      lock_valid_d = 1'b0;
      rr_last_d    = grant;
    end else if (m_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_INST;
      rr_last_q    <= ID_INST;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      rr_last_q    <= rr_last_d;
    end
  end

  sram_like_arbiter_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .push_id(grant),
    .pop    (m_dataok),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addrok, inst_dataok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addrok, data_dataok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_addrok, m_dataok;
  logic [31:0] m_rdata;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic        exp_q[$];   // 0 = inst, 1 = data, in acceptance order

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(4), .DATA_PRIO(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addrok(inst_addrok), .inst_dataok(inst_dataok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addrok(data_addrok), .data_dataok(data_dataok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addrok(m_addrok), .m_dataok(m_dataok), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0;
    inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    m_addrok = 0; m_dataok = 0;
  endtask

  // Drive a slave return this step, then check routing against the scoreboard.
  task automatic ret(input logic [31:0] rd, input string tag);
    logic id;
    m_dataok = 1'b1; m_rdata = rd;
    #1;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending id", tag);
    end
    if (exp_q.size() != 0) begin
      id = exp_q.pop_front();
      chk({tag, "_inst_dataok"}, 32'(inst_dataok), 32'(!id));
      chk({tag, "_data_dataok"}, 32'(data_dataok), 32'(id));
      chk({tag, "_inst_rdata"}, inst_rdata, rd);
      chk({tag, "_data_rdata"}, data_rdata, rd);
    end
  endtask

  initial begin
    idle();
    m_rdata = 32'h0;
    resetn  = 1'b0;
    #12;
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_inst_addrok", 32'(inst_addrok), 0);
    chk("rst_data_addrok", 32'(data_addrok), 0);
    chk("rst_dataok", 32'({inst_dataok, data_dataok}), 0);
    @(negedge clk); resetn = 1'b1;

    // Single inst read: accept in step 0, return in step 2
    @(negedge clk); idle(); inst_req = 1; inst_addr = 32'hbfc00000; m_addrok = 1; #1;
    chk("t1_m_req", 32'(m_req), 1);
    chk("t1_m_addr", m_addr, 32'hbfc00000);
    chk("t1_inst_addrok", 32'(inst_addrok), 1);
    chk("t1_data_addrok", 32'(data_addrok), 0);
    exp_q.push_back(1'b0);
    @(negedge clk); idle(); #1;
    chk("t1_idle_addrok", 32'(inst_addrok), 0);
    chk("t1_idle_dataok", 32'({inst_dataok, data_dataok}), 0);
    @(negedge clk); idle(); ret(32'h3c080001, "t1_ret");

    // Conflict: data wins, inst next cycle, returns in order
    @(negedge clk); idle();
    inst_req = 1; inst_addr = 32'hbfc00004;
    data_req = 1; data_addr = 32'h80001000; data_wr = 1; data_size = 2'd1;
    data_wstrb = 4'b0011; data_wdata = 32'h0000beef; m_addrok = 1; #1;
    chk("t2_m_addr_d", m_addr, 32'h80001000);
    chk("t2_m_wr", 32'(m_wr), 1);
    chk("t2_m_size", 32'(m_size), 1);
    chk("t2_m_wstrb", 32'(m_wstrb), 32'h3);
    chk("t2_m_wdata", m_wdata, 32'h0000beef);
    chk("t2_data_addrok", 32'(data_addrok), 1);
    chk("t2_inst_addrok0", 32'(inst_addrok), 0);
    exp_q.push_back(1'b1);
    @(negedge clk); data_req = 0; data_wr = 0; #1;
    chk("t2_m_addr_i", m_addr, 32'hbfc00004);
    chk("t2_m_wr_i", 32'(m_wr), 0);
    chk("t2_inst_addrok", 32'(inst_addrok), 1);
    exp_q.push_back(1'b0);
    @(negedge clk); idle(); ret(32'h11111111, "t2_ret0");
    @(negedge clk); idle(); ret(32'h22222222, "t2_ret1");

    // Lock: inst presented, slave stalls 3 cycles while data rises
    @(negedge clk); idle(); inst_req = 1; inst_addr = 32'hbfc00008; #1;
    chk("t3_m_req", 32'(m_req), 1);
    chk("t3_m_addr0", m_addr, 32'hbfc00008);
    chk("t3_addrok0", 32'(inst_addrok), 0);
    @(negedge clk); data_req = 1; data_addr = 32'h80002000; #1;
    chk("t3_m_addr1", m_addr, 32'hbfc00008);
    chk("t3_data_addrok1", 32'(data_addrok), 0);
    @(negedge clk); #1;
    chk("t3_m_addr2", m_addr, 32'hbfc00008);
    @(negedge clk); m_addrok = 1; #1;
    chk("t3_m_addr3", m_addr, 32'hbfc00008);
    chk("t3_inst_addrok", 32'(inst_addrok), 1);
    chk("t3_data_addrok3", 32'(data_addrok), 0);
    exp_q.push_back(1'b0);
    @(negedge clk); inst_req = 0; #1;
    chk("t3_m_addr4", m_addr, 32'h80002000);
    chk("t3_data_addrok", 32'(data_addrok), 1);
    exp_q.push_back(1'b1);
    @(negedge clk); idle(); ret(32'h33333333, "t3_ret0");
    @(negedge clk); idle(); ret(32'h44444444, "t3_ret1");

    // Full: four accepts, fifth blocked until a pop has landed
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); data_req = 1; data_addr = 32'h80004000 + 32'(i * 4); m_addrok = 1; #1;
      chk("t4_fill_addrok", 32'(data_addrok), 1);
      exp_q.push_back(1'b1);
    end
    @(negedge clk); data_addr = 32'h80004010; #1;
    chk("t4_full_m_req", 32'(m_req), 0);
    chk("t4_full_addrok", 32'(data_addrok), 0);
    @(negedge clk); ret(32'h55550000, "t4_pop");
    chk("t4_pop_m_req", 32'(m_req), 0);
    chk("t4_pop_addrok", 32'(data_addrok), 0);
    @(negedge clk); m_dataok = 0; #1;
    chk("t4_after_m_req", 32'(m_req), 1);
    chk("t4_after_addrok", 32'(data_addrok), 1);
    exp_q.push_back(1'b1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); idle(); ret(32'h55550000 + 32'(i), "t4_drain");
    end

    // Reset mid-flight: two outstanding, inst lock held, then reset
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1000 + 32'(i * 4); m_addrok = 1; #1;
      chk("t6_acc", 32'(inst_addrok), 1);
    end
    @(negedge clk); idle(); inst_req = 1; inst_addr = 32'h1008; #1;
    chk("t6_lock_addr", m_addr, 32'h1008);
    @(negedge clk); data_req = 1; data_addr = 32'h80003000; #1;
    chk("t6_locked_addr", m_addr, 32'h1008);
    @(negedge clk); resetn = 1'b0; #1;
    chk("t6_rst_unlocked", m_addr, 32'h80003000);
    chk("t6_rst_addrok", 32'({inst_addrok, data_addrok}), 0);
    #1 resetn = 1'b1;
    exp_q.delete();

    // Spurious return after reset (count is 0): ignored
    @(negedge clk); idle(); m_dataok = 1; m_rdata = 32'hdeadbeef; #1;
    chk("t5_spur_dataok", 32'({inst_dataok, data_dataok}), 0);
    chk("t5_spur_mirror", inst_rdata, 32'hdeadbeef);
    @(negedge clk); idle(); m_dataok = 1; m_rdata = 32'hcafef00d; #1;
    chk("t5_spur2_dataok", 32'({inst_dataok, data_dataok}), 0);

    // Normal read afterwards completes correctly
    @(negedge clk); idle(); data_req = 1; data_addr = 32'h80005000; m_addrok = 1; #1;
    chk("t5_acc", 32'(data_addrok), 1);
    exp_q.push_back(1'b1);
    @(negedge clk); idle(); ret(32'h66666666, "t5_ret");
    @(negedge clk); idle(); #1;
    chk("t5_end_dataok", 32'({inst_dataok, data_dataok}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
